// File: rtl/sequence_game_pkg.sv
// Shared types and helpers for the sequence memory game.
//   state_t  : FSM states, encoded with the codes shown on the hex display
//   LFSR_TAP*: feedback taps of the 16-bit Fibonacci note generator
//   onehot8  : one-hot decode of a note index for LED/key comparison
package sequence_game_pkg;

  typedef enum logic [3:0] {
    S_IDLE         = 4'd0,
    S_EXTEND       = 4'd1,
    S_PLAY_ON      = 4'd2,
    S_PLAY_GAP     = 4'd3,
    S_WAIT_PRESS   = 4'd4,
    S_WAIT_RELEASE = 4'd5,
    S_ROUND_WIN    = 4'd6,
    S_WON          = 4'd7,
    S_LOST         = 4'd8
  } state_t;

  localparam int unsigned LFSR_W    = 16;
  localparam int unsigned LFSR_TAP0 = 15;
  localparam int unsigned LFSR_TAP1 = 13;
  localparam int unsigned LFSR_TAP2 = 12;
  localparam int unsigned LFSR_TAP3 = 10;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/sequence_lfsr.sv
// 16-bit Fibonacci LFSR used as the note source.
//   i_clk     : system clock
//   i_resetn  : asynchronous active-low reset, loads the seed
//   i_advance : shift one step this cycle
//   o_low     : low byte of the current (pre-advance) state
module sequence_lfsr
  import sequence_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0001
) (
  input  logic       i_clk,
  input  logic       i_resetn,
  input  logic       i_advance,
  output logic [7:0] o_low
);

  // An all-zero state would lock up the register.
  localparam logic [15:0] SEED_EFF = (SEED == '0) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] r_q;
  logic              w_fb;

  assign w_fb = r_q[LFSR_TAP0] ^ r_q[LFSR_TAP1] ^ r_q[LFSR_TAP2] ^ r_q[LFSR_TAP3];

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_q <= SEED_EFF;
    end else if (i_advance) begin
      r_q <= {r_q[LFSR_W-2:0], w_fb};
    end
  end

  assign o_low = r_q[7:0];

endmodule

// File: rtl/sequence_game_engine.sv
// Memory game core: grows a random note sequence, plays it on the LEDs,
// then checks the player's presses against it with a per-press timeout.
//   clk, resetn : clock, asynchronous active-low reset
//   start       : one-cycle pulse, starts a game from IDLE/WON/LOST
//   keys        : debounced active-high buttons
//   led         : note display / key echo
//   state_code  : current FSM state code
//   level       : current sequence length
//   won, lost   : high while in WON / LOST
module sequence_game_engine
  import sequence_game_pkg::*;
#(
  parameter int unsigned NUM_KEYS       = 4,
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned NOTE_CYCLES    = 25000000,
  parameter int unsigned GAP_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000,
  parameter logic [15:0] SEED           = 16'h0001
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic [NUM_KEYS-1:0] keys,
  output logic [NUM_KEYS-1:0] led,
  output logic [3:0]          state_code,
  output logic [3:0]          level,
  output logic                won,
  output logic                lost
);

  localparam int unsigned NOTE_W    = (NUM_KEYS <= 2) ? 1 : $clog2(NUM_KEYS);
  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;
  logic [NOTE_W-1:0]   r_seq [MAX_LEN];
  logic [3:0]          r_len;
  logic [3:0]          r_idx;
  logic [31:0]         r_timer;
  logic [NUM_KEYS-1:0] r_keys_prev;
  logic                r_won;
  logic                r_lost;

  logic [7:0]          w_lfsr_low;
  logic [7:0]          w_mod;
  logic [NOTE_W-1:0]   w_note;
  logic [NOTE_W-1:0]   w_cur_note;
  logic [7:0]          w_oh8;
  logic [7:0]          w_keys8;
  logic                w_press;
  logic                w_timeout;
  logic                w_gap_done;
  logic [NUM_KEYS-1:0] w_led;

  sequence_lfsr #(
    .SEED(SEED)
  ) u_lfsr (
    .i_clk    (clk),
    .i_resetn (resetn),
    .i_advance(r_state == S_EXTEND),
    .o_low    (w_lfsr_low)
  );

  assign w_mod  = w_lfsr_low % 8'(NUM_KEYS);
  assign w_note = w_mod[NOTE_W-1:0];

  // Mux the note at the play/check index out of the store.
  always_comb begin
    w_cur_note = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      if (r_idx == 4'(i)) w_cur_note = r_seq[i];
    end
  end

  assign w_oh8      = onehot8(3'(w_cur_note));
  assign w_keys8    = 8'(keys);
  assign w_press    = (keys != '0) && (r_keys_prev == '0);
  assign w_timeout  = (TIMEOUT_CYCLES != 0) && (r_timer == TMO_LAST);
  assign w_gap_done = (r_timer == GAP_LAST);

  // State register and datapath
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_idx       <= '0;
      r_timer     <= '0;
      r_keys_prev <= '0;
      r_won       <= 1'b0;
      r_lost      <= 1'b0;
      for (int unsigned i = 0; i < MAX_LEN; i++) r_seq[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_keys_prev <= keys;
      r_won       <= (w_next == S_WON);
      r_lost      <= (w_next == S_LOST);
      // One timer serves every state; it restarts on each state change.
      r_timer     <= (w_next != r_state) ? '0 : r_timer + 32'd1;

      case (r_state)
        S_IDLE, S_WON, S_LOST: begin
          if (start) r_len <= '0;
        end
        S_EXTEND: begin
          for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (r_len == 4'(i)) r_seq[i] <= w_note;
          end
          r_len <= r_len + 4'd1;
          r_idx <= '0;
        end
        S_PLAY_GAP: begin
          if (w_next == S_PLAY_ON)         r_idx <= r_idx + 4'd1;
          else if (w_next == S_WAIT_PRESS) r_idx <= '0;
        end
        S_WAIT_RELEASE: begin
          if (keys == '0) r_idx <= r_idx + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (start) w_next = S_EXTEND;
      S_EXTEND:   w_next = S_PLAY_ON;
      S_PLAY_ON:  if (r_timer == NOTE_LAST) w_next = S_PLAY_GAP;
      S_PLAY_GAP: begin
        if (w_gap_done) w_next = ((r_idx + 4'd1) < r_len) ? S_PLAY_ON : S_WAIT_PRESS;
      end
      S_WAIT_PRESS: begin
        // Expiry wins over a press landing in the same cycle.
        if (w_timeout)    w_next = S_LOST;
        else if (w_press) w_next = (w_keys8 == w_oh8) ? S_WAIT_RELEASE : S_LOST;
      end
      S_WAIT_RELEASE: begin
        if (keys == '0) w_next = ((r_idx + 4'd1) == r_len) ? S_ROUND_WIN : S_WAIT_PRESS;
      end
      S_ROUND_WIN: begin
        if (w_gap_done) w_next = (r_len == 4'(MAX_LEN)) ? S_WON : S_EXTEND;
      end
      S_WON, S_LOST: if (start) w_next = S_EXTEND;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    w_led = '0;
    case (r_state)
      S_PLAY_ON:                     w_led = w_oh8[NUM_KEYS-1:0];
      S_WAIT_PRESS, S_WAIT_RELEASE:  w_led = keys;
      S_ROUND_WIN, S_WON:            w_led = '1;
      default:                       w_led = '0;
    endcase
  end

  assign led        = w_led;
  assign state_code = r_state;
  assign level      = r_len;
  assign won        = r_won;
  assign lost       = r_lost;

endmodule

// File: tb/tb_sequence_game_engine.sv
module tb_sequence_game_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [3:0] keys;
  logic [3:0] led;
  logic [3:0] state_code;
  logic [3:0] level;
  logic       won;
  logic       lost;

  int errors = 0;
  int checks = 0;

  sequence_game_engine #(
    .NUM_KEYS      (4),
    .MAX_LEN       (3),
    .NOTE_CYCLES   (2),
    .GAP_CYCLES    (1),
    .TIMEOUT_CYCLES(20),
    .SEED          (16'h0001)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .keys      (keys),
    .led       (led),
    .state_code(state_code),
    .level     (level),
    .won       (won),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start  = 1'b0;
    keys   = 4'b0000;
    tick(2);
    resetn = 1'b1;
  endtask

  task automatic begin_game();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Called in EXTEND; checks the playback of n notes (note j in oh[4j+:4]).
  task automatic play_and_check(input logic [11:0] oh, input int n, input string tag);
    tick(1);
    for (int j = 0; j < n; j++) begin
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (state_code !== 4'd2 || led !== oh[4*j +: 4]) begin
          errors++;
          $display("FAIL %s play note%0d: state=%0d led=%b expected state=2 led=%b", tag, j, state_code, led, oh[4*j +: 4]);
        end
        tick(1);
      end
      checks++;
      if (state_code !== 4'd3 || led !== 4'b0000) begin
        errors++;
        $display("FAIL %s gap%0d: state=%0d led=%b expected state=3 led=0000", tag, j, state_code, led);
      end
      tick(1);
    end
    checks++;
    if (state_code !== 4'd4) begin
      errors++;
      $display("FAIL %s wait_press: state=%0d expected 4", tag, state_code);
    end
  endtask

  task automatic press_release(input logic [3:0] k, input logic [3:0] exp_after, input string tag);
    keys = k;
    tick(1);
    checks++;
    if (state_code !== 4'd5 || led !== k) begin
      errors++;
      $display("FAIL %s press: state=%0d led=%b expected state=5 led=%b", tag, state_code, led, k);
    end
    keys = 4'b0000;
    tick(1);
    checks++;
    if (state_code !== exp_after) begin
      errors++;
      $display("FAIL %s release: state=%0d expected %0d", tag, state_code, exp_after);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (led !== 4'b0 || state_code !== 4'd0 || level !== 4'd0 || won !== 1'b0 || lost !== 1'b0) begin
      errors++;
      $display("FAIL reset: led=%b state=%0d level=%0d won=%b lost=%b expected all zero", led, state_code, level, won, lost);
    end
    begin_game();
    checks++;
    if (state_code !== 4'd1) begin
      errors++;
      $display("FAIL extend: state=%0d expected 1", state_code);
    end
    play_and_check(12'h002, 1, "first_round");
    checks++;
    if (level !== 4'd1) begin
      errors++;
      $display("FAIL first_level: level=%0d expected 1", level);
    end
  endtask

  task automatic test_full_game();
    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "game_r1");
    press_release(4'b0010, 4'd6, "game_r1_k0");
    checks++;
    if (led !== 4'b1111) begin
      errors++;
      $display("FAIL round_win_led: led=%b expected 1111", led);
    end
    tick(1);
    play_and_check(12'h042, 2, "game_r2");
    press_release(4'b0010, 4'd4, "game_r2_k0");
    press_release(4'b0100, 4'd6, "game_r2_k1");
    tick(1);
    play_and_check(12'h142, 3, "game_r3");
    press_release(4'b0010, 4'd4, "game_r3_k0");
    press_release(4'b0100, 4'd4, "game_r3_k1");
    press_release(4'b0001, 4'd6, "game_r3_k2");
    tick(1);
    checks++;
    if (state_code !== 4'd7 || won !== 1'b1 || lost !== 1'b0 || level !== 4'd3 || led !== 4'b1111) begin
      errors++;
      $display("FAIL won: state=%0d won=%b lost=%b level=%0d led=%b expected 7 1 0 3 1111", state_code, won, lost, level, led);
    end
    tick(3);
    checks++;
    if (state_code !== 4'd7) begin
      errors++;
      $display("FAIL won_hold: state=%0d expected 7", state_code);
    end
  endtask

  task automatic test_wrong_press();
    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "wrong_r1");
    press_release(4'b0010, 4'd6, "wrong_r1_k0");
    tick(1);
    play_and_check(12'h042, 2, "wrong_r2");
    press_release(4'b0010, 4'd4, "wrong_r2_k0");
    keys = 4'b0001;
    tick(1);
    checks++;
    if (state_code !== 4'd8 || lost !== 1'b1 || won !== 1'b0 || led !== 4'b0000) begin
      errors++;
      $display("FAIL wrong_lost: state=%0d lost=%b won=%b led=%b expected 8 1 0 0000", state_code, lost, won, led);
    end
    keys = 4'b0000;
    tick(1);
    keys = 4'b0100;
    tick(1);
    checks++;
    if (state_code !== 4'd8 || led !== 4'b0000) begin
      errors++;
      $display("FAIL lost_ignores_keys: state=%0d led=%b expected 8 0000", state_code, led);
    end
    keys = 4'b0000;
    begin_game();
    tick(1);
    // LFSR advanced twice this game (0x0001 -> 0x0004): next note 0.
    checks++;
    if (state_code !== 4'd2 || level !== 4'd1 || lost !== 1'b0 || led !== 4'b0001) begin
      errors++;
      $display("FAIL restart: state=%0d level=%0d lost=%b led=%b expected 2 1 0 0001", state_code, level, lost, led);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "tmo_a");
    tick(19);
    checks++;
    if (state_code !== 4'd4) begin
      errors++;
      $display("FAIL tmo_before: state=%0d expected 4", state_code);
    end
    tick(1);
    checks++;
    if (state_code !== 4'd8 || lost !== 1'b1) begin
      errors++;
      $display("FAIL tmo_expire: state=%0d lost=%b expected 8 1", state_code, lost);
    end

    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "tmo_b");
    tick(19);
    keys = 4'b0010;
    tick(1);
    checks++;
    if (state_code !== 4'd8) begin
      errors++;
      $display("FAIL tmo_press_at_expiry: state=%0d expected 8", state_code);
    end
    keys = 4'b0000;

    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "tmo_c");
    tick(18);
    press_release(4'b0010, 4'd6, "tmo_last_cycle");
  endtask

  task automatic test_multi_key();
    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "multi_a");
    keys = 4'b0011;
    tick(1);
    checks++;
    if (state_code !== 4'd8) begin
      errors++;
      $display("FAIL two_keys: state=%0d expected 8", state_code);
    end
    keys = 4'b0000;

    do_reset();
    begin_game();
    play_and_check(12'h002, 1, "multi_b");
    keys = 4'b0010;
    tick(1);
    keys = 4'b0011;
    tick(1);
    checks++;
    if (state_code !== 4'd5 || led !== 4'b0011) begin
      errors++;
      $display("FAIL extra_key_held: state=%0d led=%b expected 5 0011", state_code, led);
    end
    keys = 4'b0000;
    tick(1);
    checks++;
    if (state_code !== 4'd6) begin
      errors++;
      $display("FAIL extra_key_release: state=%0d expected 6", state_code);
    end
  endtask

  task automatic test_reset_midgame();
    do_reset();
    begin_game();
    tick(1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checks++;
    if (state_code !== 4'd2 || led !== 4'b0010 || level !== 4'd1) begin
      errors++;
      $display("FAIL start_in_play: state=%0d led=%b level=%0d expected 2 0010 1", state_code, led, level);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (state_code !== 4'd0 || led !== 4'b0000 || level !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: state=%0d led=%b level=%0d expected 0 0000 0", state_code, led, level);
    end
    tick(1);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    keys   = 4'b0000;
    test_reset();
    test_full_game();
    test_wrong_press();
    test_timeout();
    test_multi_key();
    test_reset_midgame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
